inst_rom: RTL and testbench
===========================

INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 SHALL have parameter INST_MEM_DEPTH, default 1024, instruction memory size in 32-bit words (power of two, 2..65536).
REQ-002 SHALL have parameter FETCH_RESET_WORD, default 32'h00000000, value driven on instruction when no valid fetch is presented.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port chip_enable  input  1  fetch request qualifier from the PC stage; 1 = fetch.
REQ-006 SHALL have port program_counter  input  32  byte address of the instruction to fetch.
REQ-007 SHALL have port instruction  output  32  fetched instruction word, registered.
REQ-008 SHALL have port instruction_valid  output  1  instruction holds a valid fetch result.
REQ-009 SHALL have port fetch_fault  output  1  registered; the last fetch was misaligned or out of range.
REQ-010 SHALL have port load_start  input  1  single-cycle request to begin loading the memory from word 0.
REQ-011 SHALL have port load_valid  input  1  load_data is presented.
REQ-012 SHALL have port load_data  input  32  instruction word to write.
REQ-013 SHALL have port load_last  input  1  qualifies the final word of a load burst.
REQ-014 SHALL have port load_ready  output  1  the block accepts load words.
REQ-015 SHALL have port load_done  output  1  single-cycle pulse when a load completes.

Function
REQ-016 SHALL implement a two-state FSM: RUN (serves fetches) and LOAD (accepts load words); reset state RUN.
REQ-017 Word index SHALL be program_counter[log2(INST_MEM_DEPTH)+1:2]; program_counter[1:0] SHALL be 00 for an aligned fetch.
REQ-018 In RUN, with chip_enable=1, aligned, and program_counter < 4*INST_MEM_DEPTH: instruction <= mem[index], instruction_valid <= 1, fetch_fault <= 0 at the next edge. Latency is exactly 1 cycle.
REQ-019 In RUN, with chip_enable=1 and program_counter[1:0]!=00 or program_counter >= 4*INST_MEM_DEPTH: instruction <= FETCH_RESET_WORD, instruction_valid <= 0, fetch_fault <= 1.
REQ-020 With chip_enable=0 (any state): instruction <= FETCH_RESET_WORD, instruction_valid <= 0, fetch_fault <= 0.
REQ-021 In LOAD: instruction <= FETCH_RESET_WORD, instruction_valid <= 0, fetch_fault <= 0, regardless of chip_enable (the fetch stalls).
REQ-022 RUN with load_start=1 SHALL move to LOAD and clear write_pointer to 0. A fetch presented in the same cycle SHALL be serviced per REQ-018/019.
REQ-023 load_ready SHALL be 1 exactly while in LOAD. A word is accepted on an edge where load_valid=1 and load_ready=1.
REQ-024 An accepted word SHALL be written to mem[write_pointer], and write_pointer SHALL increment by 1.
REQ-025 Load completion: an accepted word with load_last=1, or an accepted word at write_pointer = INST_MEM_DEPTH-1. On completion the FSM SHALL return to RUN, and load_done SHALL be 1 for the following cycle only. write_pointer SHALL NOT wrap.
REQ-026 load_start while in LOAD SHALL be ignored; load_valid while in RUN SHALL be ignored, with no write.
REQ-027 A fetch issued the cycle after load completion SHALL return the newly written data.
REQ-028 Unwritten locations SHALL read as their prior content; memory is not initialized by the block.

Reset
REQ-029 At an edge with reset=1: FSM <= RUN, write_pointer <= 0, instruction <= FETCH_RESET_WORD, instruction_valid <= 0, fetch_fault <= 0, load_done <= 0, load_ready <= 0.
REQ-030 reset SHALL take priority over every other input.
REQ-031 Reset during LOAD SHALL abort the load without asserting load_done. Words already written SHALL remain in memory.
REQ-032 The memory array SHALL NOT be cleared by reset.

Verification
REQ-033 Load then fetch: load_start, then 4 words 0x11111111, 0x22222222, 0x33333333, 0x44444444 (last on the 4th) -> load_done pulses once. With chip_enable=1 and PC 0x0, 0x4, 0x8, 0xC -> those words appear one cycle after each PC, with instruction_valid=1.
REQ-034 Misaligned/out of range: PC=0x00000002 -> instruction=0, instruction_valid=0, fetch_fault=1. PC=0x00001000 (depth 1024) -> same response.
REQ-035 Stall: fetch during LOAD with chip_enable=1 -> instruction_valid=0 every LOAD cycle. After load_done, the PC 0x0 fetch returns the new word.
REQ-036 Full-depth load: 1024 words with load_last never set -> completion on the word at index 1023, load_done pulses, state RUN. A further load_valid writes nothing (mem[0] unchanged).
REQ-037 Reset mid-load: reset after 2 of 4 words -> load_ready=0, no load_done. mem[0], mem[1] hold the new data; mem[2] holds the old data.
REQ-038 Reset/chip_enable: reset=1 with chip_enable=1 -> instruction_valid=0 and fetch_fault=0 while reset is held. The first valid instruction appears one cycle after the first edge with reset=0 and chip_enable=1.

Source files
------------

// File: rtl/inst_rom.sv
// Instruction memory with a registered fetch port and a word-serial loader.
// The loader stalls fetches while it fills the array starting at word 0.
module inst_rom #(
    parameter int          INST_MEM_DEPTH   = 1024,
    parameter logic [31:0] FETCH_RESET_WORD = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        chip_enable,
    input  logic [31:0] program_counter,
    output logic [31:0] instruction,
    output logic        instruction_valid,
    output logic        fetch_fault,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        load_done
);

    localparam int AW = (INST_MEM_DEPTH > 1) ? $clog2(INST_MEM_DEPTH) : 1;

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] LOAD = 1'b1;

    logic [31:0] mem [INST_MEM_DEPTH];

    logic [0:0]  state;
    logic [AW:0] write_pointer;

    logic [AW-1:0] fetch_index;
    logic [AW-1:0] write_index;
    logic          aligned;
    logic          in_range;
    logic          accept;
    logic          last_slot;

    assign fetch_index = program_counter[AW+1:2];
    assign write_index = write_pointer[AW-1:0];
    assign aligned     = (program_counter[1:0] == 2'b00);
    assign in_range    = (program_counter[31:AW+2] == '0);
    assign load_ready  = (state == LOAD);
    assign accept      = load_ready && load_valid;
    assign last_slot   = (write_pointer == (AW+1)'(INST_MEM_DEPTH - 1));

    // Array has no reset; contents survive reset and aborted loads.
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            mem[write_index] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= RUN;
            write_pointer     <= '0;
            instruction       <= FETCH_RESET_WORD;
            instruction_valid <= 1'b0;
            fetch_fault       <= 1'b0;
            load_done         <= 1'b0;
        end else begin
            instruction       <= FETCH_RESET_WORD;
            instruction_valid <= 1'b0;
            fetch_fault       <= 1'b0;
            load_done         <= 1'b0;
            unique case (state)
                RUN: begin
                    if (chip_enable) begin
                        if (aligned && in_range) begin
                            instruction       <= mem[fetch_index];
                            instruction_valid <= 1'b1;
                        end else begin
                            fetch_fault <= 1'b1;
                        end
                    end
                    if (load_start) begin
                        state         <= LOAD;
                        write_pointer <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        write_pointer <= write_pointer + 1'b1;
                        if (load_last || last_slot) begin
                            state     <= RUN;
                            load_done <= 1'b1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_rom.sv
// Randomized bench for inst_rom against a cycle-level behavioural model.
// The model tracks memory contents and the load burst in plain arrays.
module tb_inst_rom;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] RW    = 32'h00000000;

    logic        clock = 1'b0;
    logic        reset;
    logic        chip_enable;
    logic [31:0] program_counter;
    logic [31:0] instruction;
    logic        instruction_valid;
    logic        fetch_fault;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;

    inst_rom #(
        .INST_MEM_DEPTH  (DEPTH),
        .FETCH_RESET_WORD(RW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .chip_enable      (chip_enable),
        .program_counter  (program_counter),
        .instruction      (instruction),
        .instruction_valid(instruction_valid),
        .fetch_fault      (fetch_fault),
        .load_start       (load_start),
        .load_valid       (load_valid),
        .load_data        (load_data),
        .load_last        (load_last),
        .load_ready       (load_ready),
        .load_done        (load_done)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_loading = 0;
    int          m_wp = 0;

    logic [31:0] e_ins;
    bit          e_ins_known;
    bit          e_valid;
    bit          e_fault;
    bit          e_done;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_fetch();
        e_ins = RW; e_ins_known = 1; e_valid = 0; e_fault = 0;
        if (!chip_enable) return;
        if (program_counter % 4 != 0 ||
            program_counter >= 32'(4 * DEPTH)) begin
            e_fault = 1;
        end else begin
            e_valid     = 1;
            e_ins       = m_mem[program_counter / 4];
            e_ins_known = m_known[program_counter / 4];
        end
    endtask

    // One clock: predict from current inputs, then compare after the edge.
    task automatic tick();
        e_ins = RW; e_ins_known = 1; e_valid = 0; e_fault = 0; e_done = 0;
        if (reset) begin
            m_loading = 0;
            m_wp      = 0;
        end else if (!m_loading) begin
            model_fetch();
            if (load_start) begin
                m_loading = 1;
                m_wp      = 0;
            end
        end else if (load_valid) begin
            m_mem[m_wp]   = load_data;
            m_known[m_wp] = 1;
            m_wp++;
            if (load_last || m_wp == DEPTH) begin
                m_loading = 0;
                e_done    = 1;
            end
        end
        @(posedge clock);
        #1;
        if (e_ins_known) check("instruction", instruction, e_ins);
        check("valid", 32'(instruction_valid), 32'(e_valid));
        check("fault", 32'(fetch_fault), 32'(e_fault));
        check("ready", 32'(load_ready), 32'(m_loading));
        check("done", 32'(load_done), 32'(e_done));
    endtask

    task automatic idle_inputs();
        reset = 0; chip_enable = 0; program_counter = 0;
        load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
    endtask

    function automatic logic [31:0] rand_pc();
        int kind;
        kind = $urandom_range(0, 9);
        if (kind < 6) return 32'($urandom_range(0, DEPTH - 1) * 4);
        if (kind < 8) return 32'($urandom_range(0, DEPTH - 1) * 4
                                 + $urandom_range(1, 3));
        if (kind == 8) return 32'(4 * DEPTH + $urandom_range(0, 64) * 4);
        return $urandom | 32'h8000_0000;
    endfunction

    task automatic load_burst(input int n, input bit use_last);
        load_start = 1;
        tick();
        load_start = 0;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                load_valid = 0;
                tick();
            end
            load_valid = 1;
            load_data  = $urandom;
            load_last  = use_last && (i == n - 1);
            tick();
        end
        load_valid = 0;
        load_last  = 0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        idle_inputs();

        // Reset held with a fetch pending.
        reset = 1; chip_enable = 1; program_counter = 0;
        repeat (3) tick();
        reset = 0;
        tick();

        // Full-depth load without load_last; completes on word 1023.
        chip_enable = 0;
        load_burst(DEPTH, 0);
        load_valid = 1; load_data = 32'hDEAD_BEEF;
        tick();
        load_valid = 0;
        chip_enable = 1; program_counter = 0;
        tick();
        program_counter = 32'((DEPTH - 1) * 4);
        tick();

        // Four-word burst, then fetch those words back to back.
        chip_enable = 0;
        load_start = 1;
        tick();
        load_start = 0; load_valid = 1;
        for (int i = 0; i < 4; i++) begin
            load_data = 32'h1111_1111 * (i + 1);
            load_last = (i == 3);
            tick();
        end
        load_valid = 0; load_last = 0;
        chip_enable = 1;
        for (int i = 0; i < 4; i++) begin
            program_counter = 32'(4 * i);
            tick();
        end

        // Misaligned and out-of-range fetches.
        program_counter = 32'h0000_0002;
        tick();
        program_counter = 32'h0000_1000;
        tick();

        // Fetch stalled across a load; fetch same cycle as load_start.
        program_counter = 32'h10;
        load_burst(6, 1);
        program_counter = 0;
        tick();

        // Reset two words into a four-word load.
        chip_enable = 0;
        load_start = 1;
        tick();
        load_start = 0; load_valid = 1;
        for (int i = 0; i < 2; i++) begin
            load_data = 32'hA5A5_0000 + 32'(i);
            tick();
        end
        load_valid = 0; reset = 1;
        tick();
        reset = 0; chip_enable = 1;
        for (int i = 0; i < 3; i++) begin
            program_counter = 32'(4 * i);
            tick();
        end

        // Random traffic over fetches, loads and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            reset           = ($urandom_range(0, 99) == 0);
            chip_enable     = ($urandom_range(0, 3) != 0);
            program_counter = rand_pc();
            load_start      = ($urandom_range(0, 39) == 0);
            load_valid      = ($urandom_range(0, 1) == 0);
            load_data       = $urandom;
            load_last       = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
